// File: rtl/jmb_scanline_sequencer_pkg.sv
// Shared definitions for the scanline sequencer: state encodings, pixel width,
// filter tap count and the window depths derived from it.
package jmb_scanline_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_FLUSH = 2'd2
    } seq_state_t;

    localparam int PIXEL_BITS   = 8;
    localparam int FILTER_TAPS  = 5;
    // Pushes needed before the first centre pixel reaches the middle tap.
    localparam int PRIME_DEPTH  = FILTER_TAPS / 2 + 1;
    // Pixels at each line end that cannot see a full window.
    localparam int BORDER_WIDTH = FILTER_TAPS / 2;
    // First push index whose centre has a full window of real pixels.
    localparam int FILTER_START = PRIME_DEPTH + BORDER_WIDTH;

endpackage

// File: rtl/jmb_scanline_sequencer.sv
// Upstream control stage for the 5-tap scanline filter.
// Accepts one line of pixels over a valid/ready stream, primes the filter
// window, flushes the tail with zero pixels and marks border pixels as
// pass-through.
// Ports:
//   clock, reset_n          clock, asynchronous active-low reset
//   start, line_width       begin a line of line_width pixels (IDLE only)
//   abort                   drop the current line and return to IDLE
//   in_pixel/in_valid/in_ready  input pixel stream
//   filt_enable/filt_pixel_in/filt_pixel_wr/filt_pixel_filter  filter strobes
//   busy                    line in progress
//   line_done               one-cycle pulse with the final flush push
module jmb_scanline_sequencer
    import jmb_scanline_sequencer_pkg::*;
#(
    parameter int WIDTH_BITS = 12
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [WIDTH_BITS-1:0] line_width,
    input  logic                  abort,
    input  logic [PIXEL_BITS-1:0] in_pixel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  filt_enable,
    output logic [PIXEL_BITS-1:0] filt_pixel_in,
    output logic                  filt_pixel_wr,
    output logic                  filt_pixel_filter,
    output logic                  busy,
    output logic                  line_done
);

    localparam int IDX_BITS = WIDTH_BITS + 1;

    seq_state_t            state_q, state_d;
    logic [IDX_BITS-1:0]   idx_q, idx_d;
    logic [WIDTH_BITS-1:0] width_q, width_d;

    logic                  en_q, en_d;
    logic [PIXEL_BITS-1:0] pix_q, pix_d;
    logic                  wr_q, wr_d;
    logic                  flt_q, flt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  push;
    logic [PIXEL_BITS-1:0] push_pix;
    logic [IDX_BITS-1:0]   width_ext;

    assign width_ext = {1'b0, width_q};
    assign in_ready  = (state_q == ST_FEED);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        width_d  = width_q;
        push     = 1'b0;
        push_pix = '0;
        en_d     = 1'b0;
        pix_d    = pix_q;
        wr_d     = 1'b0;
        flt_d    = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && (line_width != '0)) begin
                    state_d = ST_FEED;
                    idx_d   = '0;
                    width_d = line_width;
                end
            end
            ST_FEED: begin
                // abort wins over a same-cycle handshake: the pixel is dropped.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (in_valid) begin
                    push     = 1'b1;
                    push_pix = in_pixel;
                    idx_d    = idx_q + IDX_BITS'(1);
                    if (idx_q == width_ext - IDX_BITS'(1)) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    push     = 1'b1;
                    push_pix = '0;
                    idx_d    = idx_q + IDX_BITS'(1);
                    if (idx_q == width_ext + IDX_BITS'(PRIME_DEPTH - 1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (push) begin
            en_d  = 1'b1;
            pix_d = push_pix;
            wr_d  = (idx_q >= IDX_BITS'(PRIME_DEPTH));
            // Centre k-3 is filtered only when both neighbours on each side
            // are real pixels; for short lines this range is empty.
            flt_d = (idx_q >= IDX_BITS'(FILTER_START)) && (idx_q <= width_ext);
        end
    end

    // Registering busy from the next state keeps it aligned with state_q.
    assign busy_d = (state_d == ST_FEED) || (state_d == ST_FLUSH);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            width_q <= '0;
            en_q    <= 1'b0;
            pix_q   <= '0;
            wr_q    <= 1'b0;
            flt_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            width_q <= width_d;
            en_q    <= en_d;
            pix_q   <= pix_d;
            wr_q    <= wr_d;
            flt_q   <= flt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign filt_enable       = en_q;
    assign filt_pixel_in     = pix_q;
    assign filt_pixel_wr     = wr_q;
    assign filt_pixel_filter = flt_q;
    assign busy              = busy_q;
    assign line_done         = done_q;

endmodule

// File: tb/tb_jmb_scanline_sequencer.sv
module tb_jmb_scanline_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [11:0] line_width;
    logic        abort;
    logic [7:0]  in_pixel;
    logic        in_valid;
    logic        in_ready;
    logic        filt_enable;
    logic [7:0]  filt_pixel_in;
    logic        filt_pixel_wr;
    logic        filt_pixel_filter;
    logic        busy;
    logic        line_done;

    jmb_scanline_sequencer #(.WIDTH_BITS(12)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .start             (start),
        .line_width        (line_width),
        .abort             (abort),
        .in_pixel          (in_pixel),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .filt_enable       (filt_enable),
        .filt_pixel_in     (filt_pixel_in),
        .filt_pixel_wr     (filt_pixel_wr),
        .filt_pixel_filter (filt_pixel_filter),
        .busy              (busy),
        .line_done         (line_done)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-line capture of pushes seen on the filter strobes.
    logic        mon_en;
    int          mon_n;
    int          stray;
    logic [31:0] wr_mask;
    logic [31:0] flt_mask;
    logic [31:0] done_mask;
    logic [7:0]  mon_pix [32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic clear_mon();
        mon_n     = 0;
        stray     = 0;
        wr_mask   = '0;
        flt_mask  = '0;
        done_mask = '0;
        for (int k = 0; k < 32; k++) mon_pix[k] = '0;
    endtask

    task automatic sample();
        if (filt_enable) begin
            if (mon_n < 32) begin
                mon_pix[mon_n]   = filt_pixel_in;
                wr_mask[mon_n]   = filt_pixel_wr;
                flt_mask[mon_n]  = filt_pixel_filter;
                done_mask[mon_n] = line_done;
            end
            mon_n++;
        end else if (filt_pixel_wr || filt_pixel_filter || line_done) begin
            stray++;
        end
    endtask

    // One clock cycle: sample mid-cycle, then step past the next rising edge.
    task automatic tick(output logic hs);
        @(negedge clock);
        hs = in_valid && in_ready;
        if (mon_en) sample();
        @(posedge clock);
        #1;
    endtask

    task automatic send_start(input int w);
        logic hs;
        start      = 1'b1;
        line_width = 12'(w);
        tick(hs);
        start      = 1'b0;
    endtask

    // Feed w pixels base+step*i. Optionally stall every other cycle, assert
    // abort together with the handshake of pixel abort_at, or stop once
    // stop_at pixels have been accepted.
    task automatic feed(input string tag, input int w, input int base, input int step,
                        input bit toggle, input int abort_at, input int stop_at);
        int   i;
        int   cyc;
        int   target;
        logic hs;
        i      = 0;
        cyc    = 0;
        target = (stop_at >= 0) ? stop_at : w;
        while (i < target && cyc < 200) begin
            in_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            in_pixel = 8'(base + step * i);
            abort    = (i == abort_at) && in_valid;
            tick(hs);
            cyc++;
            if (abort) begin
                abort    = 1'b0;
                in_valid = 1'b0;
                return;
            end
            if (hs) i++;
        end
        in_valid = 1'b0;
        if (cyc >= 200) check({tag, "_feed_timeout"}, 32'(i), 32'(target));
    endtask

    task automatic wait_idle(input string tag);
        int   c;
        logic hs;
        for (c = 0; c < 60; c++) begin
            if (!busy) break;
            tick(hs);
        end
        if (c >= 60) check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
        tick(hs);
    endtask

    task automatic check_line(input string tag, input int w, input int base, input int step,
                              input int n_exp, input logic [31:0] wr_exp,
                              input logic [31:0] flt_exp, input logic [31:0] done_exp);
        check({tag, "_pushes"},    32'(mon_n), 32'(n_exp));
        check({tag, "_wr_mask"},   wr_mask,    wr_exp);
        check({tag, "_flt_mask"},  flt_mask,   flt_exp);
        check({tag, "_done_mask"}, done_mask,  done_exp);
        check({tag, "_stray"},     32'(stray), 32'd0);
        for (int k = 0; k < n_exp && k < 32; k++) begin
            check($sformatf("%s_pix%0d", tag, k), 32'(mon_pix[k]),
                  (k < w) ? 32'(8'(base + step * k)) : 32'd0);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready),          32'd0);
        check({tag, "_busy"},     32'(busy),              32'd0);
        check({tag, "_en"},       32'(filt_enable),       32'd0);
        check({tag, "_wr"},       32'(filt_pixel_wr),     32'd0);
        check({tag, "_flt"},      32'(filt_pixel_filter), 32'd0);
        check({tag, "_done"},     32'(line_done),         32'd0);
    endtask

    initial begin
        logic hs;
        reset_n    = 1'b0;
        start      = 1'b0;
        line_width = '0;
        abort      = 1'b0;
        in_pixel   = '0;
        in_valid   = 1'b0;
        mon_en     = 1'b0;
        clear_mon();

        #2;
        check_quiet("reset");
        check("reset_pix", 32'(filt_pixel_in), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // W=8, continuous valid.
        clear_mon();
        mon_en = 1'b1;
        send_start(8);
        check("w8_busy", 32'(busy), 32'd1);
        check("w8_ready", 32'(in_ready), 32'd1);
        feed("w8", 8, 10, 10, 1'b0, -1, -1);
        wait_idle("w8");
        check_line("w8", 8, 10, 10, 11, 32'h7F8, 32'h1E0, 32'h400);

        // W=8, valid every other cycle.
        clear_mon();
        send_start(8);
        feed("w8s", 8, 10, 10, 1'b1, -1, -1);
        wait_idle("w8s");
        check_line("w8s", 8, 10, 10, 11, 32'h7F8, 32'h1E0, 32'h400);

        // W=3: short line, nothing filtered.
        clear_mon();
        send_start(3);
        feed("w3", 3, 1, 1, 1'b0, -1, -1);
        wait_idle("w3");
        check_line("w3", 3, 1, 1, 6, 32'h38, 32'h0, 32'h20);

        // W=0: start ignored.
        clear_mon();
        send_start(0);
        check_quiet("w0_a");
        tick(hs);
        check_quiet("w0_b");
        check("w0_pushes", 32'(mon_n), 32'd0);

        // W=10 aborted on the handshake of pixel 4.
        clear_mon();
        send_start(10);
        feed("abt", 10, 100, 1, 1'b0, 4, -1);
        check_quiet("abt_after");
        check("abt_pix_hold", 32'(filt_pixel_in), 32'd103);
        tick(hs);
        tick(hs);
        check_line("abt", 10, 100, 1, 4, 32'h08, 32'h0, 32'h0);

        // Clean W=5 line after the abort.
        clear_mon();
        send_start(5);
        feed("w5", 5, 5, 1, 1'b0, -1, -1);
        wait_idle("w5");
        check_line("w5", 5, 5, 1, 8, 32'hF8, 32'h20, 32'h80);

        // Asynchronous reset at idx=6 of a W=10 line.
        mon_en = 1'b0;
        send_start(10);
        feed("rst", 10, 50, 1, 1'b0, -1, 6);
        check("rst_pre_en", 32'(filt_enable), 32'd1);
        check("rst_pre_pix", 32'(filt_pixel_in), 32'd55);
        #1;
        reset_n = 1'b0;
        #1;
        check_quiet("rst_async");
        check("rst_async_pix", 32'(filt_pixel_in), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        clear_mon();
        mon_en = 1'b1;
        send_start(3);
        check("rst_restart_busy", 32'(busy), 32'd1);
        feed("rst_w3", 3, 7, 2, 1'b0, -1, -1);
        wait_idle("rst_w3");
        check_line("rst_w3", 3, 7, 2, 6, 32'h38, 32'h0, 32'h20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
